// File: rtl/sdram_pkg.sv
// ---------------------------------------------------------------------------
// sdram_pkg
//
// Shared definitions for the SDRAM write-side data path.
//
// Contents:
//   DATA_W_DEF      default SDRAM data width
//   DEPTH_DEF       default write FIFO depth in words
//   WRITE_TIMES     bursts per write session
//   BURST_LEN       words per burst
//   TRIG_LEVEL_DEF  words per write session (WRITE_TIMES x BURST_LEN)
//   sess_state_t    one-hot session FSM encoding (S_IDLE/S_ARMED/S_ACTIVE)
//   nextCount()     occupancy helper used to look one cycle ahead
// ---------------------------------------------------------------------------
package sdram_pkg;

   localparam int DATA_W_DEF     = 16;
   localparam int DEPTH_DEF      = 512;
   localparam int WRITE_TIMES    = 64;
   localparam int BURST_LEN      = 4;
   localparam int TRIG_LEVEL_DEF = WRITE_TIMES * BURST_LEN;

   // One-hot so each state decodes from a single flop.
   typedef enum logic [2:0] {
      S_IDLE   = 3'b001,
      S_ARMED  = 3'b010,
      S_ACTIVE = 3'b100
   } sess_state_t;

   // Occupancy after this cycle's push/pop, evaluated at 32 bits and
   // narrowed by the caller to the FIFO count width.
   function automatic int nextCount(input int count, input logic push, input logic pop);
      return count + (push ? 1 : 0) - (pop ? 1 : 0);
   endfunction

endpackage

// File: rtl/sdram_wr_fifo.sv
// ---------------------------------------------------------------------------
// sdram_wr_fifo
//
// Synchronous first-word-fall-through FIFO. The word at the read pointer is
// always visible on o_head; a pop simply advances past it. The caller is
// trusted never to push when full or pop when empty -- no checking here.
//
// Parameters:
//   DATA_W  word width
//   DEPTH   number of words, power of two
//
// Ports:
//   i_clock      rising-edge clock
//   i_reset      synchronous active-high reset (pointers and count only)
//   i_push       write i_push_data this cycle
//   i_push_data  word to write
//   i_pop        drop the head word this cycle
//   o_head       current head word (valid while !o_empty)
//   o_full       count == DEPTH
//   o_empty      count == 0
//   o_count      current occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module sdram_wr_fifo #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 512
) (
   input  logic                     i_clock,
   input  logic                     i_reset,
   input  logic                     i_push,
   input  logic [DATA_W-1:0]        i_push_data,
   input  logic                     i_pop,
   output logic [DATA_W-1:0]        o_head,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [CW-1:0]     r_count;

   // Storage array. Left unreset on purpose so it maps onto plain RAM;
   // nothing downstream looks at a word before it has been written.
   always_ff @(posedge i_clock) begin
      if (i_push) begin
         r_mem[r_wr_ptr] <= i_push_data;
      end
   end

   // Pointers wrap naturally at DEPTH because DEPTH is a power of two.
   // The count is kept separately so full and empty stay unambiguous
   // when the pointers coincide.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (i_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // The head is read straight out of the array, which is what makes the
   // FIFO fall-through: a word written at one edge is visible right after.
   assign o_head  = r_mem[r_rd_ptr];
   assign o_full  = (r_count == CW'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;

endmodule

// File: rtl/sdram_wr_feeder.sv
// ---------------------------------------------------------------------------
// sdram_wr_feeder
//
// Write-data feeder in front of the SDRAM write engine. User words are
// buffered in a FWFT FIFO; once a whole session (TRIG_LEVEL words) is held,
// write_trig is raised and kept high until the engine starts pulling data.
// Every cycle the engine asserts data_vld one word is presented on
// sdram_wdata with zero latency, and the DQ drive enable follows data_vld.
// Pulling from an empty FIFO, or pulling with no session running, latches
// the sticky underflow flag.
//
// Build option:
//   WR_FEED_TESTPAT_EN  when defined, in_data/in_valid are ignored,
//                       in_ready is tied low, and an internal counter
//                       starting at 0 fills the FIFO whenever it is not
//                       full (SDRAM bring-up pattern).
//
// Parameters:
//   DATA_W      SDRAM data width
//   DEPTH       FIFO depth, power of two, >= TRIG_LEVEL
//   TRIG_LEVEL  words per write session, >= 1
//
// Ports:
//   sysclk_100M  clock, all flops on its rising edge
//   rst          synchronous active-high reset
//   in_data      user write word
//   in_valid     in_data is valid
//   in_ready     FIFO not full (registered); push = in_valid && in_ready
//   write_trig   session request, high while the session is armed
//   data_vld     engine consumes one word this cycle
//   sdram_wdata  word for DQ, zero unless a real pop happens
//   sdram_dq_oe  DQ output enable, equal to data_vld
//   fill_level   FIFO occupancy
//   underflow    sticky protocol/underflow error
// ---------------------------------------------------------------------------
module sdram_wr_feeder
   import sdram_pkg::*;
#(
   parameter int DATA_W     = DATA_W_DEF,
   parameter int DEPTH      = DEPTH_DEF,
   parameter int TRIG_LEVEL = TRIG_LEVEL_DEF
) (
   input  logic                     sysclk_100M,
   input  logic                     rst,
   input  logic [DATA_W-1:0]        in_data,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic                     write_trig,
   input  logic                     data_vld,
   output logic [DATA_W-1:0]        sdram_wdata,
   output logic                     sdram_dq_oe,
   output logic [$clog2(DEPTH):0]   fill_level,
   output logic                     underflow
);

   localparam int CW  = $clog2(DEPTH) + 1;
   localparam int PCW = $clog2(TRIG_LEVEL + 1);

   localparam logic [CW-1:0]  TRIG_COUNT = CW'(TRIG_LEVEL);
   localparam logic [CW-1:0]  FULL_COUNT = CW'(DEPTH);
   localparam logic [PCW-1:0] LAST_POP   = PCW'(TRIG_LEVEL - 1);

   logic              w_push;
   logic              w_pop;
   logic [DATA_W-1:0] w_push_data;
   logic [DATA_W-1:0] w_head;
   logic              w_full;
   logic              w_empty;
   logic [CW-1:0]     w_count;
   logic [CW-1:0]     w_count_next;

   sess_state_t       r_state;
   logic [PCW-1:0]    r_pop_cnt;
   logic              r_write_trig;
   logic              r_underflow;
   logic              r_in_ready;

   // Only a real word leaves the FIFO; an empty-FIFO data_vld is an
   // underflow and must not move the read pointer.
   assign w_pop = data_vld && !w_empty;

`ifdef WR_FEED_TESTPAT_EN
   logic [DATA_W-1:0] r_pat;

   // Bring-up pattern: push an incrementing count whenever there is room,
   // wrapping naturally at 2^DATA_W. The user port is locked out.
   always_ff @(posedge sysclk_100M) begin
      if (rst) begin
         r_pat <= '0;
      end else if (w_push) begin
         r_pat <= r_pat + DATA_W'(1);
      end
   end

   assign w_push      = !w_full;
   assign w_push_data = r_pat;
   assign in_ready    = 1'b0;
`else
   assign w_push      = in_valid && r_in_ready;
   assign w_push_data = in_data;
   assign in_ready    = r_in_ready;
`endif

   sdram_wr_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .i_clock     (sysclk_100M),
      .i_reset     (rst),
      .i_push      (w_push),
      .i_push_data (w_push_data),
      .i_pop       (w_pop),
      .o_head      (w_head),
      .o_full      (w_full),
      .o_empty     (w_empty),
      .o_count     (w_count)
   );

   // Occupancy one cycle ahead, so the registered in_ready tracks the
   // count it will sit next to instead of lagging it by a cycle.
   assign w_count_next = CW'(nextCount(int'(w_count), w_push, w_pop));

   // Session control, in_ready and the sticky error flag.
   // The session counts data_vld cycles rather than successful pops so an
   // underflowing engine still terminates its session. Leaving S_ACTIVE
   // always passes through S_IDLE, which guarantees write_trig drops for
   // at least one cycle between sessions. write_trig is written alongside
   // the state so it always equals (state == S_ARMED).
   always_ff @(posedge sysclk_100M) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_pop_cnt    <= '0;
         r_write_trig <= 1'b0;
         r_underflow  <= 1'b0;
         r_in_ready   <= 1'b0;
      end else begin
         r_in_ready <= (w_count_next != FULL_COUNT);

         if (data_vld && (w_empty || r_state == S_IDLE)) begin
            r_underflow <= 1'b1;
         end

         unique case (r_state)
            S_IDLE: begin
               if (w_count >= TRIG_COUNT) begin
                  r_state      <= S_ARMED;
                  r_write_trig <= 1'b1;
               end
            end
            S_ARMED: begin
               if (data_vld) begin
                  r_write_trig <= 1'b0;
                  if (TRIG_LEVEL == 1) begin
                     r_state   <= S_IDLE;
                     r_pop_cnt <= '0;
                  end else begin
                     r_state   <= S_ACTIVE;
                     r_pop_cnt <= PCW'(1);
                  end
               end
            end
            S_ACTIVE: begin
               if (data_vld) begin
                  if (r_pop_cnt == LAST_POP) begin
                     r_state   <= S_IDLE;
                     r_pop_cnt <= '0;
                  end else begin
                     r_pop_cnt <= r_pop_cnt + PCW'(1);
                  end
               end
            end
            default: begin
               r_state      <= S_IDLE;
               r_pop_cnt    <= '0;
               r_write_trig <= 1'b0;
            end
         endcase
      end
   end

   // The DQ path is combinational from data_vld so the word lands in the
   // same cycle the engine asks for it; zero whenever nothing is popped.
   assign sdram_wdata = w_pop ? w_head : '0;
   assign sdram_dq_oe = data_vld;
   assign write_trig  = r_write_trig;
   assign fill_level  = w_count;
   assign underflow   = r_underflow;

endmodule
